// File: rtl/return_addr_stack.sv
// return_addr_stack: circular hardware return-address stack with sticky overflow/underflow flags
module return_addr_stack #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] push_data,
    input  logic                  clear_err,
    output logic [ADDR_WIDTH-1:0] top_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] SP_ONE = 1;
    localparam logic [DEPTH_LOG2:0] CNT_ONE = 1;
    localparam logic [DEPTH_LOG2:0] CNT_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] sp_q, sp_d, top_idx, waddr;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d, we, do_push, do_pop;

    assign top_idx   = sp_q - SP_ONE;
    assign empty     = count_q == '0;
    assign full      = count_q == CNT_DEPTH;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign top_data  = empty ? '0 : mem_q[top_idx];
    assign do_push   = enable & push;
    assign do_pop    = enable & pop;

    // decode push/pop into pointer, count, flag and write-port updates
    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        ovf_d   = ovf_q & ~clear_err;
        unf_d   = unf_q & ~clear_err;
        we      = 1'b0;
        waddr   = sp_q;
        if (do_push && do_pop && !empty) begin
            we    = 1'b1;
            waddr = top_idx;
        end else if (do_push) begin
            we    = 1'b1;
            sp_d  = sp_q + SP_ONE;
            if (full) ovf_d = 1'b1;
            else count_d = count_q + CNT_ONE;
            if (do_pop) unf_d = 1'b1;
        end else if (do_pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                sp_d    = sp_q - SP_ONE;
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // control state register; reset overrides any operation in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // storage needs no reset; writes are suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (we && !reset) mem_q[waddr] <= push_data;
    end
endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: directed vectors with a queue-based scoreboard for return_addr_stack
module tb_return_addr_stack;
    typedef struct packed {
        logic [3:0]  cnt;
        logic        empty;
        logic        full;
        logic [11:0] top;
        logic        ovf;
        logic        unf;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [11:0] push_data = '0;
    logic        clear_err = 1'b0;
    logic [11:0] top_data;
    logic        empty, full, overflow, underflow;
    logic [3:0]  count;

    obs_t  exp_q [$];
    string name_q [$];
    int    compared = 0;
    int    mismatched = 0;

    return_addr_stack #(.ADDR_WIDTH(12), .DEPTH_LOG2(3)) dut (
        .clk(clk), .reset(reset), .enable(enable), .push(push), .pop(pop),
        .push_data(push_data), .clear_err(clear_err), .top_data(top_data),
        .empty(empty), .full(full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // drive one cycle of inputs, then queue the state expected after that edge
    task automatic op(input logic r, input logic en, input logic pu, input logic po,
                      input logic [11:0] d, input logic ce, input string name,
                      input int ecnt, input logic [11:0] etop, input logic eovf, input logic eunf);
        obs_t e;
        reset = r; enable = en; push = pu; pop = po; push_data = d; clear_err = ce;
        @(posedge clk);
        e.cnt = 4'(ecnt);
        e.empty = ecnt == 0;
        e.full = ecnt == 8;
        e.top = etop;
        e.ovf = eovf;
        e.unf = eunf;
        exp_q.push_back(e);
        name_q.push_back(name);
        #1;
    endtask

    // monitor: compare every queued expectation against the registered outputs
    always @(negedge clk) begin
        obs_t e, g;
        string n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            g = {count, empty, full, top_data, overflow, underflow};
            compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL %s: got cnt=%0d empty=%b full=%b top=%h ovf=%b unf=%b, expected cnt=%0d empty=%b full=%b top=%h ovf=%b unf=%b",
                         n, g.cnt, g.empty, g.full, g.top, g.ovf, g.unf,
                         e.cnt, e.empty, e.full, e.top, e.ovf, e.unf);
            end
        end
    end

    initial begin
        op(1, 0, 0, 0, 12'h000, 0, "reset", 0, 12'h000, 0, 0);
        op(0, 1, 0, 0, 12'h000, 0, "idle", 0, 12'h000, 0, 0);
        op(0, 1, 1, 0, 12'h010, 0, "lifo_push1", 1, 12'h010, 0, 0);
        op(0, 1, 1, 0, 12'h020, 0, "lifo_push2", 2, 12'h020, 0, 0);
        op(0, 1, 1, 0, 12'h030, 0, "lifo_push3", 3, 12'h030, 0, 0);
        op(0, 1, 0, 1, 12'h000, 0, "lifo_pop1", 2, 12'h020, 0, 0);
        op(0, 1, 0, 1, 12'h000, 0, "lifo_pop2", 1, 12'h010, 0, 0);
        op(0, 1, 0, 1, 12'h000, 0, "lifo_pop3", 0, 12'h000, 0, 0);
        for (int i = 1; i <= 9; i++)
            op(0, 1, 1, 0, 12'(12'h100 + i), 0, $sformatf("ovf_push%0d", i),
               (i > 8) ? 8 : i, 12'(12'h100 + i), i == 9, 0);
        for (int k = 1; k <= 8; k++)
            op(0, 1, 0, 1, 12'h000, 0, $sformatf("ovf_pop%0d", k),
               8 - k, (k < 8) ? 12'(12'h109 - k) : 12'h000, 1, 0);
        op(0, 1, 0, 0, 12'h000, 1, "clear_ovf", 0, 12'h000, 0, 0);
        op(0, 1, 0, 1, 12'h000, 0, "unf_pop", 0, 12'h000, 0, 1);
        op(0, 1, 0, 0, 12'h000, 0, "unf_sticky", 0, 12'h000, 0, 1);
        op(0, 1, 0, 0, 12'h000, 1, "clear_unf", 0, 12'h000, 0, 0);
        op(0, 1, 0, 1, 12'h000, 1, "unf_beats_clear", 0, 12'h000, 0, 1);
        op(0, 0, 0, 0, 12'h000, 1, "clear_while_stalled", 0, 12'h000, 0, 0);
        op(0, 1, 1, 0, 12'h0AA, 0, "pp_push_aa", 1, 12'h0AA, 0, 0);
        op(0, 1, 1, 0, 12'h0BB, 0, "pp_push_bb", 2, 12'h0BB, 0, 0);
        op(0, 1, 1, 1, 12'h0CC, 0, "pp_replace", 2, 12'h0CC, 0, 0);
        op(0, 1, 0, 1, 12'h000, 0, "pp_pop", 1, 12'h0AA, 0, 0);
        op(0, 1, 0, 1, 12'h000, 0, "pp_pop_last", 0, 12'h000, 0, 0);
        op(0, 1, 1, 1, 12'h055, 0, "pp_empty", 1, 12'h055, 0, 1);
        op(0, 1, 0, 0, 12'h000, 1, "pp_empty_clear", 1, 12'h055, 0, 0);
        op(0, 1, 0, 1, 12'h000, 0, "pp_empty_pop", 0, 12'h000, 0, 0);
        op(0, 1, 1, 0, 12'h011, 0, "stall_push1", 1, 12'h011, 0, 0);
        op(0, 1, 1, 0, 12'h022, 0, "stall_push2", 2, 12'h022, 0, 0);
        op(0, 1, 1, 0, 12'h033, 0, "stall_push3", 3, 12'h033, 0, 0);
        op(0, 0, 1, 0, 12'h077, 0, "stall_push", 3, 12'h033, 0, 0);
        op(0, 0, 0, 1, 12'h000, 0, "stall_pop", 3, 12'h033, 0, 0);
        op(1, 1, 1, 0, 12'h099, 0, "reset_with_push", 0, 12'h000, 0, 0);
        op(0, 1, 0, 1, 12'h000, 0, "post_reset_pop", 0, 12'h000, 0, 1);
        op(1, 1, 0, 0, 12'h000, 0, "reset_clears_unf", 0, 12'h000, 0, 0);
        op(0, 1, 1, 0, 12'h044, 0, "post_reset_push", 1, 12'h044, 0, 0);
        op(0, 1, 0, 1, 12'h000, 0, "post_reset_pop2", 0, 12'h000, 0, 0);
        enable = 1'b0; push = 1'b0; pop = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
